// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues req/ack word reads to instruction
// memory and buffers returned words with their PC in a small FIFO toward decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [31:0]      PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      drain_addr;
  logic [31:0]      buf_inst [DEPTH];
  logic [31:0]      buf_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic             push;
  logic             pop;

  // Request lines depend on state only; DRAIN keeps the abandoned address on the bus.
  assign imem_req    = ~rst & (state != IDLE);
  assign imem_addr   = (state == DRAIN) ? drain_addr : fetch_pc;

  assign inst_valid  = (count != '0);
  assign inst        = buf_inst[rd_ptr];
  assign inst_pc     = buf_pc[rd_ptr];

  assign pop         = inst_valid & inst_ready;
  assign push        = (state == FETCH) & imem_ack & ~redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC & PC_MASK;
      drain_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      // Redirect flushes the buffer; a pop in the same cycle is simply absorbed.
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          buf_inst[wr_ptr] <= imem_rdata;
          buf_pc[wr_ptr]   <= fetch_pc;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_after;
      end

      unique case (state)
        IDLE: begin
          if (redirect || (count < FULL)) state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            if (!imem_ack) begin
              drain_addr <= fetch_pc;
              state      <= DRAIN;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_after >= FULL) state <= IDLE;
          end
        end
        DRAIN: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase

      if (redirect) fetch_pc <= redirect_pc & PC_MASK;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the mini-cpu, directly upstream of the decode logic (`immediate_gen`, `register_file` read ports). It owns the fetch program counter and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small FIFO and presented to decode over a valid/ready handshake. A redirect input from branch/jump resolution flushes the buffer and restarts fetch at a new address.

## Interface

- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] ignored.
- `DEPTH`, default 2: instruction buffer entries (power of two, ≥2).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address of request; bits [1:0] always 0.
- `imem_ack`  in  1  memory returns `imem_rdata`; meaningful only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] forced to 0.
- `inst_valid`  out  1  buffer head holds an instruction.
- `inst`  out  32  instruction at buffer head.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decode accepts head this cycle.

## Operation

- State machine, 3 states:
  - IDLE: `imem_req`=0. Move to FETCH when `count` < `DEPTH`.
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - On ack: push {`fetch_pc`, `imem_rdata`}; `fetch_pc` += 4.
    - After an ack, stay in FETCH if the buffer has room after this cycle's push/pop, else go to IDLE.
  - DRAIN: `imem_req`=1, address held at the abandoned request. On ack, data is discarded and the next state is FETCH at `fetch_pc`.
- Memory protocol:
  - Once raised, `imem_req` and `imem_addr` hold stable until ack.
  - Ack may arrive in the same cycle as req (zero-wait) or any later cycle.
  - At most one request outstanding.
- Buffer: FIFO of `DEPTH` entries.
  - `inst_valid` = not empty; `inst`/`inst_pc` = head entry.
  - Pop when `inst_valid` & `inst_ready`.
  - Push and pop in the same cycle are allowed.
  - Issue gating guarantees a push never targets a full buffer.
- Redirect, regardless of state:
  - Buffer is flushed: `count` = 0.
  - `fetch_pc` = {`redirect_pc`[31:2], 2'b00}.
  - In FETCH without ack this cycle: go to DRAIN.
  - In FETCH with ack this cycle: ack data is discarded, no DRAIN; next state FETCH at the new PC.
  - In DRAIN: `fetch_pc` is updated; stay in DRAIN unless ack arrives this cycle.
  - In IDLE: go to FETCH.
  - Redirect in the same cycle as a pop: the pop counts as accepted by decode.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing

- Reset (while `rst`=1 at an edge) sets:
  - state = FETCH, `fetch_pc` = `RESET_PC`, `count` = 0;
  - `inst`, `inst_pc` = 0; `inst_valid` = 0.
- `imem_req` is forced to 0 while `rst`=1.
- First request is visible in the first cycle with `rst`=0.
- Reset mid-operation abandons any outstanding request; instruction memory shares `rst`.
- Latency: a word acked in cycle n is on `inst`/`inst_valid` in cycle n+1.
- Throughput: with zero-wait memory and `inst_ready`=1, one instruction per cycle sustained.
- Redirect in cycle n, with no DRAIN needed:
  - `inst_valid`=0 in n+1;
  - request to `redirect_pc` visible in n+1;
  - that instruction valid in n+2 if zero-wait.
- `inst`, `inst_pc`, and `inst_valid` are registered/FIFO outputs with no combinational path from `inst_ready`.
- `imem_req` and `imem_addr` are combinational from state only, not from `imem_ack`.

## Test plan

- Reset release, zero-wait memory returning `addr ^ 32'hA5A5_0000`, `inst_ready`=1:
  - `inst_pc` = 0, 4, 8, 12 on consecutive cycles starting cycle 2;
  - `inst` matches the returned words.
- Memory ack delayed 3 cycles per request:
  - `imem_addr` is stable during each wait;
  - one instruction every 4 cycles;
  - no duplicated or skipped PC.
- `inst_ready`=0 for 10 cycles:
  - buffer fills to `DEPTH`=2, then `imem_req`=0 (IDLE);
  - on `inst_ready`=1, entries 0x0 and 0x4 drain in order, then fetch resumes at 0x8.
- Redirect to 32'h0000_0103 while a request to 0x10 waits (ack 2 cycles later):
  - `imem_addr` holds 0x10 until ack, and that data never appears;
  - next request is 0x100;
  - `inst_valid`=0 until 0x100 returns.
- Redirect to 0x200 in the same cycle as an ack for 0x20 and a pop:
  - 0x20 is never presented;
  - next request is 0x200 in the following cycle.
- Redirect to 32'hFFFF_FFF8:
  - `inst_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000;
  - assert `rst` mid-stream: `inst_valid`=0 next cycle, then fetch restarts at `RESET_PC`.
